fcmp_unit: RTL and testbench
============================

Name: fcmp_unit

Overview:
- Pipelined FPU reader of sign/exponent/mantissa fields for single-precision words; the inverse side of the sign-manipulation ops.
- Executes FEQ, FLT, FLE, FMIN, FMAX and FCLASS.
- Sits in the multi-cycle FPU cluster between issue and writeback, with a valid/ready handshake on both sides.
- Fixed 2-stage pipeline with full backpressure and a synchronous flush.

Parameters:
- TAG_W, 5, width of the opaque destination tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  request valid.
- in_ready  out  1  unit accepts the request this cycle.
- op  in  3  operation: 0 FEQ, 1 FLT, 2 FLE, 3 FMIN, 4 FMAX, 5 FCLASS; 6 and 7 are illegal.
- x1  in  32  operand 1 (IEEE-754 single).
- x2  in  32  operand 2; ignored for FCLASS.
- tag_in  in  TAG_W  destination tag.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts the result.
- y  out  32  result.
- tag_out  out  TAG_W  tag of the result.
- illegal  out  1  qualifies out_valid; set when op was 6 or 7.
- busy  out  1  either pipeline stage holds a valid entry.

Behaviour:
- Reset: clk edge with rst=1 clears s1_valid and s2_valid. Outputs out_valid=0, busy=0, illegal=0, y=0, tag_out=0. in_ready=1 from the first cycle after reset.
- Reset and flush mid-operation: in-flight entries are dropped silently. No partial result is emitted. rst has priority over flush; flush has priority over acceptance in the same cycle.
- Handshake:
  - Transfer occurs when valid && ready on the rising edge.
  - y, tag_out and illegal are held stable while out_valid=1 && out_ready=0.
  - out_valid never drops without a transfer, except on rst or flush.
- Pipeline:
  - Stage 1 registers the decoded fields: sign, exp==0xFF, exp==0, mant==0, mant[22]. It also registers mag_lt = x1[30:0] < x2[30:0] and mag_eq, plus op, tag and the raw operands.
  - Stage 2 registers the selected result.
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 (combinational; no combinational path from in_valid to in_ready).
- Latency: 2 cycles from accept to out_valid. Throughput is 1 per cycle with out_ready held high. A stall holds both stages, and in_ready falls only when both stages are full.
- NaN: exp==0xFF && mant!=0. It is signalling if mant[22]==0, quiet otherwise.
- Zero: x[30:0]==0, so +0 and -0 are equal.
- Compare results are 32'h0 or 32'h1:
  - Any NaN operand gives 0 for FEQ, FLT and FLE.
  - FEQ = both zero || x1==x2 (bitwise).
  - FLT for ordered operands:
    - signs differ: x1 negative && !(both zero).
    - both positive: mag_lt.
    - both negative: !mag_lt && !mag_eq.
  - FLE = FLT || FEQ.
- FMIN / FMAX:
  - One NaN operand: return the other operand.
  - Both NaN: return canonical 32'h7FC00000.
  - min(-0,+0) = 32'h80000000; max(-0,+0) = 32'h00000000, in either operand order.
  - Otherwise select by the FLT logic; on equality return x1.
- FCLASS: one-hot 10-bit mask in y[9:0], y[31:10]=0. Bit assignment:
  - 0: -inf; 1: -normal; 2: -subnormal; 3: -0.
  - 4: +0; 5: +subnormal; 6: +normal; 7: +inf.
  - 8: sNaN; 9: qNaN.
- Subnormals are classified and compared by bit pattern (no flush-to-zero).
- Illegal op: y=0, illegal=1, flowing through the pipeline normally.

Decomposition:
- Shared FPU package holds:
  - fcmp_op_e enum (FEQ..FCLASS).
  - CANON_NAN = 32'h7FC00000.
  - FCLASS bit-index constants.
  - fp_fields_t struct (sign, is_zero, is_inf, is_nan, is_snan, is_sub).
- One sub-module, fp_field_decode: purely combinational 32-bit word to fp_fields_t. Instantiated twice in stage 1 and reused later by other FPU units.

Test Plan:
- Reset then FEQ x1=32'h80000000, x2=32'h00000000, tag 3 -> out_valid exactly 2 cycles after accept, y=1, tag_out=3, illegal=0.
- FLT x1=32'hBF800000 (-1.0), x2=32'h3F800000 -> y=1. FLT x1=32'hC0000000, x2=32'hBF800000 -> y=1. FLE with x2=32'h7FC00000 -> y=0.
- FMIN 32'h7F800001 vs 32'h40000000 -> y=32'h40000000. FMAX qNaN vs qNaN -> y=32'h7FC00000. FMAX 32'h80000000 vs 32'h00000000 -> y=32'h00000000.
- FCLASS sweep over -inf, -1.0, 32'h80000001, -0, +0, 32'h00000001, 1.0, +inf, 32'h7F800001, 32'h7FC00000 -> y = 1<<0 through 1<<9 in order.
- Back-to-back 8 ops with out_ready toggling 1,0,0,1 repeatedly -> in_ready=0 only when both stages are full; no loss, duplication or reorder; y and tag_out stable during stalls.
- Two ops in flight, then flush=1 (and separately rst=1) for one cycle -> out_valid=0 next cycle, busy=0, and a following op returns normally after 2 cycles. op=7 -> illegal=1, y=0.

Source files
------------

// File: rtl/fcmp_unit_pkg.sv
// Shared FPU definitions: compare/classify opcodes, canonical NaN,
// FCLASS bit positions and the decoded-field record for a single-precision word.
package fcmp_unit_pkg;

  typedef enum logic [2:0] {
    FCMP_FEQ    = 3'd0,
    FCMP_FLT    = 3'd1,
    FCMP_FLE    = 3'd2,
    FCMP_FMIN   = 3'd3,
    FCMP_FMAX   = 3'd4,
    FCMP_FCLASS = 3'd5
  } fcmp_op_e;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [31:0] NEG_ZERO  = 32'h8000_0000;

  localparam int FCLASS_NEG_INF  = 0;
  localparam int FCLASS_NEG_NORM = 1;
  localparam int FCLASS_NEG_SUB  = 2;
  localparam int FCLASS_NEG_ZERO = 3;
  localparam int FCLASS_POS_ZERO = 4;
  localparam int FCLASS_POS_SUB  = 5;
  localparam int FCLASS_POS_NORM = 6;
  localparam int FCLASS_POS_INF  = 7;
  localparam int FCLASS_SNAN     = 8;
  localparam int FCLASS_QNAN     = 9;

  typedef struct packed {
    logic sign;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_snan;
    logic is_sub;
  } fp_fields_t;

  // One-hot class mask; anything not zero/sub/inf/nan is a normal number.
  function automatic logic [9:0] fclass_mask(input fp_fields_t f);
    logic [9:0] m;
    logic       is_norm;
    m       = '0;
    is_norm = !(f.is_zero || f.is_sub || f.is_inf || f.is_nan);
    if (f.is_nan) begin
      if (f.is_snan) m[FCLASS_SNAN] = 1'b1;
      else           m[FCLASS_QNAN] = 1'b1;
    end else if (f.sign) begin
      m[FCLASS_NEG_INF]  = f.is_inf;
      m[FCLASS_NEG_NORM] = is_norm;
      m[FCLASS_NEG_SUB]  = f.is_sub;
      m[FCLASS_NEG_ZERO] = f.is_zero;
    end else begin
      m[FCLASS_POS_INF]  = f.is_inf;
      m[FCLASS_POS_NORM] = is_norm;
      m[FCLASS_POS_SUB]  = f.is_sub;
      m[FCLASS_POS_ZERO] = f.is_zero;
    end
    return m;
  endfunction

endpackage

// File: rtl/fcmp_unit_fp_field_decode.sv
// Purely combinational split of an IEEE-754 single into its class flags.
module fp_field_decode
  import fcmp_unit_pkg::*;
(
  input  logic [31:0] x,
  output fp_fields_t  f
);

  logic exp_ff;
  logic exp_zero;
  logic mant_zero;

  // Decode exponent/mantissa extremes into the class flags.
  always_comb begin
    exp_ff    = (x[30:23] == 8'hFF);
    exp_zero  = (x[30:23] == 8'h00);
    mant_zero = (x[22:0] == 23'd0);
    f         = '0;
    f.sign    = x[31];
    f.is_zero = exp_zero && mant_zero;
    f.is_inf  = exp_ff && mant_zero;
    f.is_nan  = exp_ff && !mant_zero;
    f.is_snan = exp_ff && !mant_zero && !x[22];
    f.is_sub  = exp_zero && !mant_zero;
  end

endmodule

// File: rtl/fcmp_unit.sv
// Two-stage FP compare/min/max/classify unit with valid/ready on both sides.
// Stage 1 holds decoded operand fields, stage 2 holds the selected result.
module fcmp_unit
  import fcmp_unit_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] tag_out,
  output logic             illegal,
  output logic             busy
);

  fp_fields_t       dec1, dec2;
  logic             adv1, adv2;

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [31:0]      s1_x1, s1_x2;
  fp_fields_t       s1_f1, s1_f2;
  logic             s1_mag_lt, s1_mag_eq;

  logic             s2_valid;
  logic [31:0]      s2_y;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_ill;

  logic             any_nan, both_zero, feq, lt12, lt21;
  logic [31:0]      res_y;
  logic             res_ill;

  fp_field_decode u_dec1 (.x(x1), .f(dec1));
  fp_field_decode u_dec2 (.x(x2), .f(dec2));

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;
  assign y         = s2_y;
  assign tag_out   = s2_tag;
  assign illegal   = s2_ill;
  assign busy      = s1_valid || s2_valid;

  // Stage 1 occupancy; flush wins over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst)        s1_valid <= 1'b0;
    else if (flush) s1_valid <= 1'b0;
    else if (adv1)  s1_valid <= in_valid;
  end

  // Stage 1 payload: decoded fields, magnitude compare and raw operands.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      s1_op     <= op;
      s1_tag    <= tag_in;
      s1_x1     <= x1;
      s1_x2     <= x2;
      s1_f1     <= dec1;
      s1_f2     <= dec2;
      s1_mag_lt <= (x1[30:0] < x2[30:0]);
      s1_mag_eq <= (x1[30:0] == x2[30:0]);
    end
  end

  // Ordered less-than in both directions, used by FLT/FLE and by min/max selection.
  always_comb begin
    any_nan   = s1_f1.is_nan || s1_f2.is_nan;
    both_zero = s1_f1.is_zero && s1_f2.is_zero;
    feq       = !any_nan && (both_zero || (s1_x1 == s1_x2));
    if (s1_f1.sign != s1_f2.sign) begin
      lt12 = s1_f1.sign && !both_zero;
      lt21 = s1_f2.sign && !both_zero;
    end else if (!s1_f1.sign) begin
      lt12 = s1_mag_lt;
      lt21 = !s1_mag_lt && !s1_mag_eq;
    end else begin
      lt12 = !s1_mag_lt && !s1_mag_eq;
      lt21 = s1_mag_lt;
    end
  end

  // Result selection for the operation held in stage 1.
  always_comb begin
    res_y   = '0;
    res_ill = 1'b0;
    case (fcmp_op_e'(s1_op))
      FCMP_FEQ: res_y = {31'd0, feq};
      FCMP_FLT: res_y = {31'd0, !any_nan && lt12};
      FCMP_FLE: res_y = {31'd0, feq || (!any_nan && lt12)};
      FCMP_FMIN: begin
        if (s1_f1.is_nan && s1_f2.is_nan) res_y = CANON_NAN;
        else if (s1_f1.is_nan)            res_y = s1_x2;
        else if (s1_f2.is_nan)            res_y = s1_x1;
        else if (both_zero)               res_y = (s1_f1.sign || s1_f2.sign) ? NEG_ZERO : 32'd0;
        else                              res_y = lt21 ? s1_x2 : s1_x1;
      end
      FCMP_FMAX: begin
        if (s1_f1.is_nan && s1_f2.is_nan) res_y = CANON_NAN;
        else if (s1_f1.is_nan)            res_y = s1_x2;
        else if (s1_f2.is_nan)            res_y = s1_x1;
        else if (both_zero)               res_y = (s1_f1.sign && s1_f2.sign) ? NEG_ZERO : 32'd0;
        else                              res_y = lt12 ? s1_x2 : s1_x1;
      end
      FCMP_FCLASS: res_y = {22'd0, fclass_mask(s1_f1)};
      default: begin
        res_y   = '0;
        res_ill = 1'b1;
      end
    endcase
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_tag   <= '0;
      s2_ill   <= 1'b0;
    end else begin
      if (flush)     s2_valid <= 1'b0;
      else if (adv2) s2_valid <= s1_valid;
      if (!flush && adv2 && s1_valid) begin
        s2_y   <= res_y;
        s2_tag <= s1_tag;
        s2_ill <= res_ill;
      end
    end
  end

endmodule

// File: tb/tb_fcmp_unit.sv
// Scoreboard bench for fcmp_unit: drivers push expectations, a monitor pops on transfer.
module tb_fcmp_unit;
  import fcmp_unit_pkg::*;

  localparam int TAG_W = 5;

  typedef struct {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = '0;
  logic [31:0]      x1 = '0;
  logic [31:0]      x2 = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      y;
  logic [TAG_W-1:0] tag_out;
  logic             illegal;
  logic             busy;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   acc_cnt = 0;
  int   xf_cnt = 0;
  int   drop_cnt = 0;
  bit   chk_en = 0;
  bit   tog_en = 0;
  bit   or_fixed = 1;
  int   tog_i = 0;

  always #5 clk = ~clk;

  fcmp_unit #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x1(x1), .x2(x2), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .tag_out(tag_out), .illegal(illegal), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // out_ready pattern 1,0,0,1 when toggling, otherwise a fixed level
  always @(negedge clk) begin
    if (tog_en) begin
      out_ready = ((tog_i % 4) == 0) || ((tog_i % 4) == 3);
      tog_i++;
    end else begin
      out_ready = or_fixed;
    end
  end

  // Monitor: transfer compare, in_ready rule, hold-stable checks
  initial begin : monitor
    bit               prev_stall;
    logic [31:0]      prev_y;
    logic [TAG_W-1:0] prev_tag;
    logic             prev_ill;
    int               occ;
    exp_t             e;
    prev_stall = 0;
    prev_y = '0; prev_tag = '0; prev_ill = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (chk_en && !rst && !flush) begin
        occ = acc_cnt - xf_cnt - drop_cnt;
        chk("in_ready_rule", {31'd0, in_ready}, {31'd0, !(occ == 2 && !out_ready)});
        if (prev_stall) begin
          chk("hold_valid", {31'd0, out_valid}, 32'd1);
          chk("hold_y", y, prev_y);
          chk("hold_tag", {27'd0, tag_out}, {27'd0, prev_tag});
          chk("hold_ill", {31'd0, illegal}, {31'd0, prev_ill});
        end
        prev_stall = out_valid && !out_ready;
        prev_y = y; prev_tag = tag_out; prev_ill = illegal;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_output: got y=%h tag=%0d, expected none", y, tag_out);
          end else begin
            e = sb.pop_front();
            chk("y", y, e.y);
            chk("tag_out", {27'd0, tag_out}, {27'd0, e.tag});
            chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
          end
          @(posedge clk);
          xf_cnt++;
        end
      end else begin
        prev_stall = 0;
      end
    end
  end

  // Drive one request; returns just after the accepting edge.
  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t, input logic [31:0] ey, input logic eill);
    int   n;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; op = o; x1 = a; x2 = b; tag_in = t;
    n = 0;
    forever begin
      #1;
      if (in_ready) break;
      n++;
      if (n > 100) begin
        nvec++; nerr++;
        $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, expected 1");
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    e.y = ey; e.tag = t; e.ill = eill;
    sb.push_back(e);
    acc_cnt++;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((acc_cnt - xf_cnt - drop_cnt) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout: got %0d in flight, expected 0", acc_cnt - xf_cnt - drop_cnt);
    end
  endtask

  // Fill both stages with out_ready low, then kill them with flush or rst.
  task automatic kill_test(input bit use_rst);
    or_fixed = 0;
    @(negedge clk);
    send(FCMP_FLT, 32'h3F800000, 32'h40000000, 5'd20, 32'd1, 1'b0);
    send(FCMP_FEQ, 32'h3F800000, 32'h3F800000, 5'd21, 32'd1, 1'b0);
    idle();
    @(negedge clk);
    #1;
    chk(use_rst ? "full_before_rst" : "full_before_flush", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk);
    drop_cnt = acc_cnt - xf_cnt;
    sb.delete();
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; or_fixed = 1;
    #1;
    chk(use_rst ? "rst_out_valid" : "flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk(use_rst ? "rst_busy" : "flush_busy", {31'd0, busy}, 32'd0);
    send(FCMP_FMAX, 32'hC0000000, 32'h3F800000, 5'd22, 32'h3F800000, 1'b0);
    idle();
    #1;
    chk(use_rst ? "after_rst_lat1" : "after_flush_lat1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk(use_rst ? "after_rst_lat2" : "after_flush_lat2", {31'd0, out_valid}, 32'd1);
    drain();
  endtask

  initial begin : main
    logic [31:0] fcv [10];
    fcv = '{32'hFF800000, 32'hBF800000, 32'h80000001, 32'h80000000, 32'h00000000,
            32'h00000001, 32'h3F800000, 32'h7F800000, 32'h7F800001, 32'h7FC00000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_tag", {27'd0, tag_out}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk_en = 1;

    // latency: -0 == +0
    send(FCMP_FEQ, 32'h80000000, 32'h00000000, 5'd3, 32'd1, 1'b0);
    idle();
    #1;
    chk("lat_cycle1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("lat_cycle2", {31'd0, out_valid}, 32'd1);
    drain();

    // compares
    send(FCMP_FLT, 32'hBF800000, 32'h3F800000, 5'd4, 32'd1, 1'b0);
    send(FCMP_FLT, 32'hC0000000, 32'hBF800000, 5'd5, 32'd1, 1'b0);
    send(FCMP_FLE, 32'h3F800000, 32'h7FC00000, 5'd6, 32'd0, 1'b0);
    send(FCMP_FLT, 32'h80000000, 32'h00000000, 5'd7, 32'd0, 1'b0);
    send(FCMP_FLE, 32'h80000000, 32'h00000000, 5'd8, 32'd1, 1'b0);
    send(FCMP_FEQ, 32'h7F800001, 32'h7F800001, 5'd9, 32'd0, 1'b0);
    send(FCMP_FLT, 32'h00000001, 32'h00000002, 5'd10, 32'd1, 1'b0);
    send(FCMP_FLT, 32'hBF800000, 32'hBF800000, 5'd11, 32'd0, 1'b0);
    // min / max
    send(FCMP_FMIN, 32'h7F800001, 32'h40000000, 5'd12, 32'h40000000, 1'b0);
    send(FCMP_FMAX, 32'h7FC00000, 32'h7FC00000, 5'd13, 32'h7FC00000, 1'b0);
    send(FCMP_FMAX, 32'h7FC00001, 32'hFF800001, 5'd14, 32'h7FC00000, 1'b0);
    send(FCMP_FMAX, 32'h80000000, 32'h00000000, 5'd15, 32'h00000000, 1'b0);
    send(FCMP_FMAX, 32'h00000000, 32'h80000000, 5'd16, 32'h00000000, 1'b0);
    send(FCMP_FMIN, 32'h00000000, 32'h80000000, 5'd17, 32'h80000000, 1'b0);
    send(FCMP_FMIN, 32'h80000000, 32'h00000000, 5'd18, 32'h80000000, 1'b0);
    send(FCMP_FMIN, 32'h40000000, 32'h3F800000, 5'd19, 32'h3F800000, 1'b0);
    // fclass sweep
    for (int i = 0; i < 10; i++)
      send(FCMP_FCLASS, fcv[i], 32'h12345678, 5'(i), 32'd1 << i, 1'b0);
    // illegal opcodes
    send(3'd7, 32'h3F800000, 32'h3F800000, 5'd30, 32'd0, 1'b1);
    send(3'd6, 32'h00000000, 32'h00000000, 5'd31, 32'd0, 1'b1);
    idle();
    drain();

    // back-to-back under toggling backpressure
    tog_i = 0;
    tog_en = 1;
    send(FCMP_FLT,  32'h3F800000, 32'h40000000, 5'd10, 32'd1, 1'b0);
    send(FCMP_FLT,  32'h40000000, 32'h3F800000, 5'd11, 32'd0, 1'b0);
    send(FCMP_FEQ,  32'h3F800000, 32'h3F800000, 5'd12, 32'd1, 1'b0);
    send(FCMP_FLE,  32'h3F800000, 32'h3F800000, 5'd13, 32'd1, 1'b0);
    send(FCMP_FMIN, 32'hBF800000, 32'h3F800000, 5'd14, 32'hBF800000, 1'b0);
    send(FCMP_FMAX, 32'hBF800000, 32'h3F800000, 5'd15, 32'h3F800000, 1'b0);
    send(FCMP_FLT,  32'hC0000000, 32'hC0000000, 5'd16, 32'd0, 1'b0);
    send(FCMP_FMIN, 32'hC0000000, 32'hBF800000, 5'd17, 32'hC0000000, 1'b0);
    idle();
    drain();
    tog_en = 0;
    @(negedge clk);

    kill_test(1'b0);
    kill_test(1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule
